// File: rtl/pr_noc_pkg.sv
// Shared packet layout, FSM encoding and helpers for the PageRank ejection interface.
package pr_noc_pkg;

  localparam int unsigned PKT_WIDTH   = 31;
  localparam int unsigned PKT_VALID   = 30;
  localparam int unsigned PKT_DST_HI  = 29;
  localparam int unsigned PKT_DST_LO  = 24;
  localparam int unsigned PKT_DAT_HI  = 23;
  localparam int unsigned CONTRIB_W   = PKT_WIDTH - 7;
  localparam int unsigned NODE_ID_W   = PKT_DST_HI - PKT_DST_LO + 1;
  localparam int unsigned LOCAL_IDX_W = 4;
  localparam int unsigned CNT_W       = 11;
  localparam int unsigned MIS_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

  // Buffered packet payload; the valid bit is consumed at the FIFO input.
  typedef struct packed {
    logic [NODE_ID_W-1:0] dest;
    logic [CONTRIB_W-1:0] contrib;
  } pkt_payload_t;

  // Unsigned add that clamps at the all-ones value instead of wrapping.
  function automatic logic [CONTRIB_W-1:0] sat_add(input logic [CONTRIB_W-1:0] a,
                                                   input logic [CONTRIB_W-1:0] b);
    logic [CONTRIB_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CONTRIB_W] ? {CONTRIB_W{1'b1}} : sum[CONTRIB_W-1:0];
  endfunction

endpackage

// File: rtl/pr_eject_fifo.sv
// Synchronous ejection FIFO with a registered head word and registered status flags.
module pr_eject_fifo #(
  parameter int unsigned WIDTH = 30,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             afull
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] head_next;
  logic             push_ok;
  logic             pop_ok;

  // Qualify requests against the current flags and derive next-cycle occupancy/head.
  always_comb begin
    push_ok     = push && !full;
    pop_ok      = pop && !empty;
    rd_ptr_next = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
    count_next  = count;
    unique case ({push_ok, pop_ok})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    // A word landing in the slot that becomes the head must be taken from the write port.
    if (push_ok && (wr_ptr == rd_ptr_next)) begin
      head_next = push_data;
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  // Storage array; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy, head register and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      afull  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      head   <= head_next;
      full   <= (count_next == CW'(DEPTH));
      empty  <= (count_next == CW'(0));
      afull  <= (count_next >= CW'(DEPTH - 2));
    end
  end

endmodule

// File: rtl/pr_eject_accumulator.sv
// Router ejection-port receiver: buffers rank contributions and accumulates them per local node.
module pr_eject_accumulator
  import pr_noc_pkg::*;
#(
  parameter int unsigned WIDTH     = 31,
  parameter int unsigned DEPTH     = 16,
  parameter logic [5:0]  NODE_BASE = 6'b0,
  parameter int unsigned NODES     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             eject_write,
  input  logic [WIDTH-1:0] eject_data,
  output logic             eject_afull,
  input  logic             start,
  input  logic [10:0]      expected_cnt,
  input  logic [3:0]       rd_idx,
  output logic [WIDTH-8:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [7:0]       misroute_cnt
);

  localparam int unsigned CW    = WIDTH - 7;
  localparam int unsigned PAY_W = $bits(pkt_payload_t);

  acc_state_e       state;
  logic [CW-1:0]    acc [NODES];
  logic [CNT_W-1:0] recv_cnt;
  logic [CNT_W-1:0] exp_cnt;

  logic             push_c;
  logic             pop_c;
  logic             in_tile_c;
  logic [PAY_W-1:0] head;
  pkt_payload_t     head_pkt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_afull;

  pr_eject_fifo #(
    .WIDTH (PAY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (eject_data[PKT_DST_HI:0]),
    .pop       (pop_c),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .afull     (fifo_afull)
  );

  assign eject_afull = fifo_afull;

  // Pop only while accumulating, the count is still short, and no restart is in progress.
  always_comb begin
    head_pkt  = pkt_payload_t'(head);
    push_c    = eject_write && eject_data[PKT_VALID];
    in_tile_c = (head_pkt.dest[5:4] == NODE_BASE[5:4]);
    pop_c     = (state == ACCUM) && !fifo_empty && !start && (recv_cnt != exp_cnt);
  end

  // Iteration FSM, accumulators, counters, sticky status and read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      recv_cnt     <= '0;
      exp_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      misroute_cnt <= '0;
      rd_data      <= '0;
      for (int i = 0; i < int'(NODES); i++) begin
        acc[i] <= '0;
      end
    end else begin
      rd_data <= acc[rd_idx];

      if (push_c && fifo_full) begin
        overflow <= 1'b1;
      end

      if (start) begin
        for (int i = 0; i < int'(NODES); i++) begin
          acc[i] <= '0;
        end
        recv_cnt <= '0;
        exp_cnt  <= expected_cnt;
        state    <= ACCUM;
        busy     <= 1'b1;
        done     <= 1'b0;
      end else begin
        unique case (state)
          ACCUM: begin
            if (recv_cnt == exp_cnt) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (pop_c) begin
              if (in_tile_c) begin
                acc[head_pkt.dest[LOCAL_IDX_W-1:0]] <=
                  sat_add(acc[head_pkt.dest[LOCAL_IDX_W-1:0]], head_pkt.contrib);
              end else if (misroute_cnt != {MIS_W{1'b1}}) begin
                misroute_cnt <= misroute_cnt + MIS_W'(1);
              end
              recv_cnt <= recv_cnt + CNT_W'(1);
            end
          end
          IDLE:    ;
          DONE:    ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pr_eject_accumulator.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_pr_eject_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        eject_write;
  logic [30:0] eject_data;
  logic        eject_afull;
  logic        start;
  logic [10:0] expected_cnt;
  logic [3:0]  rd_idx;
  logic [23:0] rd_data;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [7:0]  misroute_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state.
  logic [30:0] mq[$];
  int unsigned macc[16];
  bit          m_run;
  bit          m_fin;
  bit          m_ovf;
  int          m_mis;
  int          m_recv;
  int          m_exp;

  pr_eject_accumulator #(
    .WIDTH     (31),
    .DEPTH     (16),
    .NODE_BASE (6'b010000),
    .NODES     (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .eject_write  (eject_write),
    .eject_data   (eject_data),
    .eject_afull  (eject_afull),
    .start        (start),
    .expected_cnt (expected_cnt),
    .rd_idx       (rd_idx),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .misroute_cnt (misroute_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [30:0] mk(input logic [5:0] d, input logic [23:0] c);
    return {1'b1, d, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input logic [23:0] e_rd);
    chk("rd_data", 32'(rd_data), 32'(e_rd));
    chk("busy", 32'(busy), 32'(m_run));
    chk("done", 32'(done), 32'(m_fin));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("misroute_cnt", 32'(misroute_cnt), 32'(m_mis));
    chk("eject_afull", 32'(eject_afull), 32'(mq.size() >= 14));
  endtask

  task automatic model_clear();
    mq.delete();
    foreach (macc[i]) macc[i] = 0;
    m_run = 0; m_fin = 0; m_ovf = 0; m_mis = 0; m_recv = 0; m_exp = 0;
  endtask

  // One clock: drive inputs, advance the model by the rules, then compare.
  task automatic step(input logic wr, input logic [30:0] d, input logic st, input logic [10:0] ec);
    logic [30:0] pkt;
    logic [23:0] e_rd;
    int          pre;
    bit          fin_now;
    bit          do_pop;
    int unsigned s;
    eject_write  = wr;
    eject_data   = d;
    start        = st;
    expected_cnt = ec;
    @(posedge clk);
    e_rd    = 24'(macc[rd_idx]);
    fin_now = m_run && (m_recv == m_exp);
    do_pop  = m_run && !fin_now && !st && (mq.size() != 0);
    pre     = mq.size();
    if (do_pop) begin
      pkt = mq.pop_front();
      if (pkt[29:28] == 2'b01) begin
        s = macc[pkt[27:24]] + 32'(pkt[23:0]);
        macc[pkt[27:24]] = (s > 32'hFFFFFF) ? 32'hFFFFFF : s;
      end else if (m_mis < 255) begin
        m_mis++;
      end
      m_recv++;
    end
    if (wr && d[30]) begin
      if (pre >= 16) m_ovf = 1;
      else mq.push_back(d);
    end
    if (st) begin
      foreach (macc[i]) macc[i] = 0;
      m_recv = 0; m_exp = int'(ec); m_run = 1; m_fin = 0;
    end else if (fin_now) begin
      m_run = 0; m_fin = 1;
    end
    #1;
    check_all(e_rd);
    eject_write = 1'b0;
    start       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0, '0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0; eject_write = 1'b0; start = 1'b0;
    #1;
    model_clear();
    check_all(24'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      idle(1);
      n++;
    end
    chk("wait_done", 32'(done), 32'd1);
  endtask

  task automatic read_acc(input int idx, input logic [23:0] expv, input string tag);
    rd_idx = 4'(idx);
    idle(1);
    chk(tag, 32'(rd_data), 32'(expv));
  endtask

  initial begin
    int n;
    reset = 1'b1; eject_write = 1'b0; eject_data = '0; start = 1'b0;
    expected_cnt = '0; rd_idx = '0;
    model_clear();
    reset_dut();

    // Reset in the middle of an iteration with packets queued.
    for (int i = 0; i < 5; i++) step(1'b1, mk(6'h11, 24'(i + 1)), 1'b0, '0);
    step(1'b0, '0, 1'b1, 11'd10);
    reset_dut();
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_misroute", 32'(misroute_cnt), 32'd0);
    step(1'b0, '0, 1'b1, 11'd1);
    idle(3);
    chk("t1_fifo_empty_busy", 32'(busy), 32'd1);
    read_acc(1, 24'd0, "t1_acc1");

    // Back-to-back packets into two local nodes; done latency after last pop.
    reset_dut();
    step(1'b0, '0, 1'b1, 11'd3);
    step(1'b1, mk(6'h12, 24'd100), 1'b0, '0);
    step(1'b1, mk(6'h12, 24'd50), 1'b0, '0);
    step(1'b1, mk(6'h1F, 24'd7), 1'b0, '0);
    n = 0;
    while (done !== 1'b1 && n < 10) begin
      idle(1);
      n++;
    end
    chk("t2_done_latency", 32'(n), 32'd2);
    read_acc(2, 24'd150, "t2_acc2");
    read_acc(15, 24'd7, "t2_acc15");

    // Saturation at the top of the contribution range.
    reset_dut();
    step(1'b0, '0, 1'b1, 11'd2);
    step(1'b1, mk(6'h13, 24'hFFFF00), 1'b0, '0);
    step(1'b1, mk(6'h13, 24'hFFFF00), 1'b0, '0);
    wait_done(10);
    read_acc(3, 24'hFFFFFF, "t3_sat");

    // Packet for another tile is counted but not accumulated.
    reset_dut();
    step(1'b0, '0, 1'b1, 11'd1);
    step(1'b1, mk(6'h25, 24'd5), 1'b0, '0);
    wait_done(10);
    chk("t4_misroute", 32'(misroute_cnt), 32'd1);
    for (int i = 0; i < 16; i++) read_acc(i, 24'd0, "t4_acc_zero");

    // Fill the FIFO while idle: almost-full at 14, 17th write dropped.
    reset_dut();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) step(1'b1, mk(6'(16 + i), 24'(i + 1)), 1'b0, '0);
      else        step(1'b1, mk(6'h10, 24'd1000), 1'b0, '0);
      if (i == 12) chk("t5_afull_at_13", 32'(eject_afull), 32'd0);
      if (i == 13) chk("t5_afull_at_14", 32'(eject_afull), 32'd1);
    end
    chk("t5_overflow", 32'(overflow), 32'd1);
    step(1'b0, '0, 1'b1, 11'd16);
    wait_done(40);
    for (int i = 0; i < 16; i++) read_acc(i, 24'(i + 1), "t5_retained");

    // Restart from DONE with packets waiting.
    reset_dut();
    step(1'b0, '0, 1'b1, 11'd1);
    step(1'b1, mk(6'h11, 24'd9), 1'b0, '0);
    wait_done(10);
    step(1'b1, mk(6'h11, 24'd3), 1'b0, '0);
    step(1'b1, mk(6'h14, 24'd4), 1'b0, '0);
    read_acc(1, 24'd9, "t6_before_start");
    step(1'b0, '0, 1'b1, 11'd2);
    wait_done(10);
    read_acc(1, 24'd3, "t6_acc1");
    read_acc(4, 24'd4, "t6_acc4");

    // Random traffic, restarts and reads against the model.
    reset_dut();
    for (int i = 0; i < 800; i++) begin
      logic        wr;
      logic        st;
      logic [23:0] c;
      logic [30:0] d;
      wr = 1'($urandom_range(0, 1));
      c  = ($urandom_range(0, 9) == 0) ? 24'($urandom) : 24'($urandom_range(0, 1000));
      d  = {1'($urandom_range(0, 7) != 0), 6'($urandom_range(12, 47)), c};
      st = ($urandom_range(0, 29) == 0);
      rd_idx = 4'($urandom);
      step(wr, d, st, 11'($urandom_range(0, 8)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
